// File: rtl/serial_pkg.sv
// Shared definitions for the parallel-to-serial converter: FSM encoding,
// default word length and the bit-counter width helper.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 6;

    // Counter width for a modulus-`width` counter; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serializador_paralelo_if.sv
// Load handshake plus serial output bundle between a word producer, the
// converter and the downstream shift register.
interface serializador_paralelo_if #(
    parameter int WIDTH = serial_pkg::DEFAULT_WIDTH
);

    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             serial_out;
    logic             bit_valid;
    logic             frame_done;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  serial_out,
        input  bit_valid,
        input  frame_done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output serial_out,
        output bit_valid,
        output frame_done
    );

endinterface

// File: rtl/serializador_paralelo_contador_bits.sv
// Modulus-WIDTH up-counter with synchronous clear, enable and a terminal-count
// flag marking the last bit position of a frame.
module contador_bits
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign tc = (cnt == LAST);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serializador_paralelo.sv
// Parallel-to-serial converter: takes a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per enabled clock, MSB or LSB first.
module serializador_paralelo
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    shift_en,
    serializador_paralelo_if.slave  bus,
    output logic                    busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             ready;
    logic             accept;
    logic             advance;

    // Ready is combinational so a new word can land on the last-bit edge
    // and the stream continues with no gap.
    assign ready   = reset_n & shift_en & ((state == IDLE) | tc);
    assign accept  = bus.load_valid & ready;
    assign advance = (state == SHIFT) & shift_en & ~accept;

    contador_bits #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_contador_bits (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (advance),
        .cnt     (cnt),
        .tc      (tc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (shift_en && tc && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sreg is a plain register, not a memory, so it is cleared on reset;
    // a stale partial frame must never reach serial_out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sreg <= '0;
        end else if (accept) begin
            sreg <= bus.load_data;
        end else if (advance) begin
            if (tc) begin
                sreg <= '0;
            end else if (MSB_FIRST) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
            end else begin
                sreg <= {1'b0, sreg[WIDTH-1:1]};
            end
        end
    end

    // Everything except load_ready decodes from registers and shift_en only.
    always_comb begin
        busy           = (state == SHIFT);
        bus.bit_valid  = (state == SHIFT);
        bus.serial_out = (state == SHIFT) & (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
        bus.frame_done = (state == SHIFT) & tc & shift_en;
        bus.load_ready = ready;
    end

endmodule
